// File: rtl/motor_ctrl_pkg.sv
// Shared types and constants for the line-follow motor controller: FSM encodings,
// sensor patterns, default speeds and the sensor-to-state run map.
package motor_ctrl_pkg;

  localparam int unsigned DUTY_W = 4;
  localparam int unsigned SENS_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FWD    = 3'd1,
    ST_TURN_L = 3'd2,
    ST_TURN_R = 3'd3,
    ST_SEARCH = 3'd4,
    ST_STOP   = 3'd5
  } state_e;

  // Sensor patterns are {left, centre, right}
  localparam logic [SENS_W-1:0] SNS_NONE  = 3'b000;
  localparam logic [SENS_W-1:0] SNS_R     = 3'b001;
  localparam logic [SENS_W-1:0] SNS_CTR   = 3'b010;
  localparam logic [SENS_W-1:0] SNS_CR    = 3'b011;
  localparam logic [SENS_W-1:0] SNS_L     = 3'b100;
  localparam logic [SENS_W-1:0] SNS_SPLIT = 3'b101;
  localparam logic [SENS_W-1:0] SNS_LC    = 3'b110;
  localparam logic [SENS_W-1:0] SNS_ALL   = 3'b111;

  localparam logic [DUTY_W-1:0] V_FWD_DEF  = 4'd12;
  localparam logic [DUTY_W-1:0] V_SLOW_DEF = 4'd4;

  typedef struct packed {
    logic [DUTY_W-1:0] duty;
    logic              dir;
  } wheel_cmd_t;

  function automatic state_e run_next(input logic [SENS_W-1:0] sns, input state_e cur);
    run_next = cur;
    case (sns)
      SNS_CTR:       run_next = ST_FWD;
      SNS_L, SNS_LC: run_next = ST_TURN_L;
      SNS_R, SNS_CR: run_next = ST_TURN_R;
      SNS_NONE:      run_next = ST_SEARCH;
      SNS_ALL:       run_next = ST_STOP;
      SNS_SPLIT:     run_next = cur;
      default:       run_next = cur;
    endcase
  endfunction

  function automatic logic is_running(input state_e st);
    return (st == ST_FWD) || (st == ST_TURN_L) || (st == ST_TURN_R) || (st == ST_SEARCH);
  endfunction

endpackage

// File: rtl/duty_ramp.sv
// Per-wheel duty/direction register. With MOTOR_SOFTSTART_EN defined the duty slews one
// step per strobe and only reverses at zero; otherwise it follows the target directly.
module duty_ramp
  import motor_ctrl_pkg::*;
(
  input  logic              clk_in,
  input  logic              reset,
  input  logic              step_i,
  input  logic              force_zero_i,
  input  wheel_cmd_t        tgt_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic              dir_o
);

  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              dir_q, dir_d;

`ifdef MOTOR_SOFTSTART_EN
  always_comb begin
    duty_d = duty_q;
    dir_d  = dir_q;
    if (force_zero_i) begin
      duty_d = '0;
    end else if (step_i) begin
      // A reversal first bleeds the duty to zero, then flips direction at rest
      if (tgt_i.dir != dir_q) begin
        if (duty_q != '0) duty_d = duty_q - DUTY_W'(1);
        else              dir_d  = tgt_i.dir;
      end else if (duty_q < tgt_i.duty) begin
        duty_d = duty_q + DUTY_W'(1);
      end else if (duty_q > tgt_i.duty) begin
        duty_d = duty_q - DUTY_W'(1);
      end
    end
  end
`else
  logic unused_step;
  assign unused_step = step_i;

  always_comb begin
    duty_d = force_zero_i ? '0 : tgt_i.duty;
    dir_d  = tgt_i.dir;
  end
`endif

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      duty_q <= '0;
      dir_q  <= 1'b1;
    end else begin
      duty_q <= duty_d;
      dir_q  <= dir_d;
    end
  end

  assign duty_o = duty_q;
  assign dir_o  = dir_q;

endmodule

// File: rtl/line_follow_motor_ctrl.sv
// Line-follow smart-car controller: tick prescaler, sensor sync/debounce, steering FSM and
// two duty ramps. Soft-start ramping is enabled by defining MOTOR_SOFTSTART_EN.
module line_follow_motor_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned       TICK_DIV   = 50000,
  parameter int unsigned       DEB_TICKS  = 3,
  parameter int unsigned       RAMP_TICKS = 20,
  parameter int unsigned       LOST_TICKS = 500,
  parameter logic [DUTY_W-1:0] V_FWD      = V_FWD_DEF,
  parameter logic [DUTY_W-1:0] V_SLOW     = V_SLOW_DEF
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              enable,
  input  logic [SENS_W-1:0] sensor,
  output logic [DUTY_W-1:0] duty_l,
  output logic [DUTY_W-1:0] duty_r,
  output logic              dir_l,
  output logic              dir_r,
  output logic [2:0]        state_o,
  output logic              running
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RAMP_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
  localparam int unsigned DEB_W  = $clog2(DEB_TICKS + 1);
  localparam int unsigned LOST_W = $clog2(LOST_TICKS + 1);

  logic [TICK_W-1:0] tick_cnt_q;
  logic [RAMP_W-1:0] ramp_cnt_q;
  logic              tick_c, ramp_stb_c;

  assign tick_c     = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign ramp_stb_c = tick_c && (ramp_cnt_q == RAMP_W'(RAMP_TICKS - 1));

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      ramp_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_c ? '0 : tick_cnt_q + TICK_W'(1);
      if (tick_c) ramp_cnt_q <= ramp_stb_c ? '0 : ramp_cnt_q + RAMP_W'(1);
    end
  end

  logic [SENS_W-1:0] sync1_q, sync2_q, cand_q, s_q;
  logic [DEB_W-1:0]  deb_cnt_q, deb_next_c;

  // A candidate pattern is accepted once it has been seen on DEB_TICKS consecutive ticks
  assign deb_next_c = (sync2_q == cand_q && deb_cnt_q != '0) ? deb_cnt_q + DEB_W'(1) : DEB_W'(1);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      s_q       <= SNS_NONE;
      deb_cnt_q <= '0;
    end else begin
      sync1_q <= sensor;
      sync2_q <= sync1_q;
      if (tick_c) begin
        if (sync2_q == s_q) begin
          deb_cnt_q <= '0;
        end else if (deb_next_c == DEB_W'(DEB_TICKS)) begin
          s_q       <= sync2_q;
          deb_cnt_q <= '0;
        end else begin
          cand_q    <= sync2_q;
          deb_cnt_q <= deb_next_c;
        end
      end
    end
  end

  state_e            state_q, state_d;
  logic [LOST_W-1:0] lost_q, lost_d;
  logic              last_left_q, running_q;

  always_comb begin
    state_d = state_q;
    lost_d  = '0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_FWD;
        ST_STOP: state_d = ST_STOP;
        default: begin
          state_d = run_next(s_q, state_q);
          // Lost timer only runs while SEARCH persists; any exit clears it
          if (state_q == ST_SEARCH && state_d == ST_SEARCH) begin
            lost_d = lost_q;
            if (tick_c) begin
              if (lost_q == LOST_W'(LOST_TICKS - 1)) begin
                state_d = ST_STOP;
                lost_d  = '0;
              end else begin
                lost_d = lost_q + LOST_W'(1);
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      lost_q      <= '0;
      last_left_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lost_q    <= lost_d;
      running_q <= is_running(state_d);
      if (state_q == ST_TURN_L)      last_left_q <= 1'b1;
      else if (state_q == ST_TURN_R) last_left_q <= 1'b0;
    end
  end

  wheel_cmd_t tgt_l_c, tgt_r_c;
  logic       force_zero_c;

  // Zero-duty targets keep the present direction so a wind-down never reverses a wheel
  always_comb begin
    tgt_l_c      = '{duty: '0, dir: dir_l};
    tgt_r_c      = '{duty: '0, dir: dir_r};
    force_zero_c = 1'b0;
    case (state_q)
      ST_FWD: begin
        tgt_l_c = '{duty: V_FWD, dir: 1'b1};
        tgt_r_c = '{duty: V_FWD, dir: 1'b1};
      end
      ST_TURN_L: begin
        tgt_l_c = '{duty: V_SLOW, dir: 1'b1};
        tgt_r_c = '{duty: V_FWD,  dir: 1'b1};
      end
      ST_TURN_R: begin
        tgt_l_c = '{duty: V_FWD,  dir: 1'b1};
        tgt_r_c = '{duty: V_SLOW, dir: 1'b1};
      end
      ST_SEARCH: begin
        tgt_l_c = '{duty: V_SLOW, dir: ~last_left_q};
        tgt_r_c = '{duty: V_SLOW, dir: last_left_q};
      end
      ST_STOP: force_zero_c = 1'b1;
      default: ;
    endcase
  end

  duty_ramp u_ramp_l (
    .clk_in       (clk_in),
    .reset        (reset),
    .step_i       (ramp_stb_c),
    .force_zero_i (force_zero_c),
    .tgt_i        (tgt_l_c),
    .duty_o       (duty_l),
    .dir_o        (dir_l)
  );

  duty_ramp u_ramp_r (
    .clk_in       (clk_in),
    .reset        (reset),
    .step_i       (ramp_stb_c),
    .force_zero_i (force_zero_c),
    .tgt_i        (tgt_r_c),
    .duty_o       (duty_r),
    .dir_o        (dir_r)
  );

  assign state_o = state_q;
  assign running = running_q;

endmodule
